// File: rtl/cpu_pkg.sv
// Shared core definitions: ISA opcodes, datapath widths, bubble encoding and
// the fetch FSM state encoding.
package cpu_pkg;

  localparam int CPU_PC_W    = 16;
  localparam int CPU_INSTR_W = 16;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SLL  = 4'h5;
  localparam logic [3:0] OP_SRL  = 4'h6;
  localparam logic [3:0] OP_ADDI = 4'h7;
  localparam logic [3:0] OP_LW   = 4'h8;
  localparam logic [3:0] OP_SW   = 4'h9;
  localparam logic [3:0] OP_BEQ  = 4'hA;
  localparam logic [3:0] OP_BNE  = 4'hB;
  localparam logic [3:0] OP_JAL  = 4'hC;
  localparam logic [3:0] OP_JR   = 4'hD;
  localparam logic [3:0] OP_LUI  = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  localparam logic [CPU_INSTR_W-1:0] BUBBLE_INSTR = 16'h0000;

  typedef enum logic [0:0] {
    FS_RUN    = 1'b0,
    FS_HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// Generic pipeline register with hold and flush; flush wins over hold and
// clears instruction/valid while leaving the PC field untouched.
module if_id_reg #(
  parameter int INSTR_W = 16,
  parameter int PC_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hold_i,
  input  logic               flush_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [PC_W-1:0]    pc_i,
  input  logic               valid_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_o,
  output logic               valid_o
);

  logic [INSTR_W-1:0] instr_q;
  logic [PC_W-1:0]    pc_q;
  logic               valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      instr_q <= '0;
      valid_q <= 1'b0;
    end else if (!hold_i) begin
      instr_q <= instr_i;
      pc_q    <= pc_i;
      valid_q <= valid_i;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC register, run/halt FSM and IF/ID register.
// Optional IF_PERF_CNT_EN adds saturating fetch/bubble counters.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int              PC_W     = CPU_PC_W,
  parameter int              INSTR_W  = CPU_INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic [INSTR_W-1:0] id_instr,
  output logic [PC_W-1:0]    id_pc,
  output logic               id_valid,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        bubble_cnt,
`endif
  output logic               fetch_halted
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_plus1;
  logic            is_hlt;
  logic            load_valid;
  logic            load_bubble;

  assign pc_plus1  = pc_q + PC_ONE;
  assign is_hlt    = (imem_instr[INSTR_W-1 -: 4] == OP_HLT);
  assign imem_addr = pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FS_RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (redirect)
      state_d = FS_RUN;
    else if (!stall && state_q == FS_RUN && is_hlt)
      state_d = FS_HALTED;
  end

  // Priority: redirect > stall > halt > normal
  always_comb begin
    fetch_halted = (state_q == FS_HALTED);
    load_valid   = !redirect && !stall && (state_q == FS_RUN);
    load_bubble  = redirect || (!stall && state_q == FS_HALTED);
    pc_d         = pc_q;
    if (redirect)
      pc_d = redirect_pc;
    else if (load_valid && !is_hlt)
      pc_d = pc_plus1;
  end

  if_id_reg #(
    .INSTR_W (INSTR_W),
    .PC_W    (PC_W)
  ) u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .hold_i  (stall),
    .flush_i (load_bubble),
    .instr_i (imem_instr),
    .pc_i    (pc_plus1),
    .valid_i (1'b1),
    .instr_o (id_instr),
    .pc_o    (id_pc),
    .valid_o (id_valid)
  );

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, bubble_cnt_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (load_valid)  fetch_cnt_q  <= sat_inc(fetch_cnt_q);
      if (load_bubble) bubble_cnt_q <= sat_inc(bubble_cnt_q);
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch; imem returns 16'h1000+addr, optionally
// with a HLT planted at address 7.
module tb_instr_fetch;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic [15:0] imem_addr;
  logic [15:0] imem_instr;
  logic [15:0] id_instr;
  logic [15:0] id_pc;
  logic        id_valid;
  logic        fetch_halted;
  logic        hlt_en = 1'b1;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt, bubble_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign imem_instr = (hlt_en && imem_addr == 16'h0007) ? 16'hF000 : 16'h1000 + imem_addr;

  instr_fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_addr    (imem_addr),
    .imem_instr   (imem_instr),
    .id_instr     (id_instr),
    .id_pc        (id_pc),
    .id_valid     (id_valid),
`ifdef IF_PERF_CNT_EN
    .fetch_cnt    (fetch_cnt),
    .bubble_cnt   (bubble_cnt),
`endif
    .fetch_halted (fetch_halted)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; hlt_en = 1'b1;
    #12;
    checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, 16'h0000); end
    checks++; if (id_instr !== 16'h0000) begin errors++; $display("FAIL reset_instr got=%h exp=%h", id_instr, 16'h0000); end
    checks++; if (id_pc !== 16'h0000) begin errors++; $display("FAIL reset_pc got=%h exp=%h", id_pc, 16'h0000); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", id_valid); end
    checks++; if (fetch_halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", fetch_halted); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (imem_addr !== 16'(i + 1)) begin errors++; $display("FAIL seq_addr[%0d] got=%h exp=%h", i, imem_addr, 16'(i + 1)); end
      checks++; if (id_instr !== 16'(16'h1000 + i)) begin errors++; $display("FAIL seq_instr[%0d] got=%h exp=%h", i, id_instr, 16'(16'h1000 + i)); end
      checks++; if (id_pc !== 16'(i + 1)) begin errors++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, id_pc, 16'(i + 1)); end
      checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d] got=%b exp=1", i, id_valid); end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (imem_addr !== 16'h0005) begin errors++; $display("FAIL stall_addr[%0d] got=%h exp=0005", i, imem_addr); end
      checks++; if (id_instr !== 16'h1004) begin errors++; $display("FAIL stall_instr[%0d] got=%h exp=1004", i, id_instr); end
      checks++; if (id_pc !== 16'h0005) begin errors++; $display("FAIL stall_pc[%0d] got=%h exp=0005", i, id_pc); end
      checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, id_valid); end
    end
    stall = 1'b0;
    tick();
    checks++; if (imem_addr !== 16'h0006) begin errors++; $display("FAIL stall_release_addr got=%h exp=0006", imem_addr); end
    checks++; if (id_instr !== 16'h1005) begin errors++; $display("FAIL stall_release_instr got=%h exp=1005", id_instr); end
    tick();
    checks++; if (imem_addr !== 16'h0007) begin errors++; $display("FAIL pre_halt_addr got=%h exp=0007", imem_addr); end
  endtask

  task automatic test_halt();
    tick();
    checks++; if (id_instr !== 16'hF000) begin errors++; $display("FAIL halt_instr got=%h exp=F000", id_instr); end
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL halt_valid got=%b exp=1", id_valid); end
    checks++; if (id_pc !== 16'h0008) begin errors++; $display("FAIL halt_pc got=%h exp=0008", id_pc); end
    checks++; if (imem_addr !== 16'h0007) begin errors++; $display("FAIL halt_addr got=%h exp=0007", imem_addr); end
    checks++; if (fetch_halted !== 1'b1) begin errors++; $display("FAIL halt_flag got=%b exp=1", fetch_halted); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (imem_addr !== 16'h0007) begin errors++; $display("FAIL halted_addr[%0d] got=%h exp=0007", i, imem_addr); end
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL halted_valid[%0d] got=%b exp=0", i, id_valid); end
      checks++; if (id_instr !== BUBBLE_INSTR) begin errors++; $display("FAIL halted_instr[%0d] got=%h exp=0000", i, id_instr); end
      checks++; if (id_pc !== 16'h0008) begin errors++; $display("FAIL halted_pc[%0d] got=%h exp=0008", i, id_pc); end
      checks++; if (fetch_halted !== 1'b1) begin errors++; $display("FAIL halted_flag[%0d] got=%b exp=1", i, fetch_halted); end
    end
    redirect = 1'b1; redirect_pc = 16'h0002;
    tick();
    redirect = 1'b0;
    checks++; if (imem_addr !== 16'h0002) begin errors++; $display("FAIL resume_addr got=%h exp=0002", imem_addr); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL resume_valid got=%b exp=0", id_valid); end
    checks++; if (fetch_halted !== 1'b0) begin errors++; $display("FAIL resume_flag got=%b exp=0", fetch_halted); end
    tick();
    checks++; if (id_instr !== 16'h1002) begin errors++; $display("FAIL resume_instr got=%h exp=1002", id_instr); end
    checks++; if (id_pc !== 16'h0003) begin errors++; $display("FAIL resume_pc got=%h exp=0003", id_pc); end
    checks++; if (imem_addr !== 16'h0003) begin errors++; $display("FAIL resume_next_addr got=%h exp=0003", imem_addr); end
  endtask

  task automatic test_redirect_stall();
    stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0040;
    tick();
    stall = 1'b0; redirect = 1'b0;
    checks++; if (imem_addr !== 16'h0040) begin errors++; $display("FAIL rs_addr got=%h exp=0040", imem_addr); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rs_valid got=%b exp=0", id_valid); end
    checks++; if (id_instr !== 16'h0000) begin errors++; $display("FAIL rs_instr got=%h exp=0000", id_instr); end
    checks++; if (id_pc !== 16'h0003) begin errors++; $display("FAIL rs_pc_kept got=%h exp=0003", id_pc); end
    tick();
    checks++; if (id_instr !== 16'h1040) begin errors++; $display("FAIL rs_next_instr got=%h exp=1040", id_instr); end
    checks++; if (id_pc !== 16'h0041) begin errors++; $display("FAIL rs_next_pc got=%h exp=0041", id_pc); end
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL rs_next_valid got=%b exp=1", id_valid); end
  endtask

  task automatic test_wrap_and_reset();
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    tick();
    redirect = 1'b0;
    checks++; if (imem_addr !== 16'hFFFF) begin errors++; $display("FAIL wrap_start_addr got=%h exp=FFFF", imem_addr); end
    tick();
    checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL wrap_addr got=%h exp=0000", imem_addr); end
    checks++; if (id_pc !== 16'h0000) begin errors++; $display("FAIL wrap_pc got=%h exp=0000", id_pc); end
    checks++; if (id_instr !== 16'h0FFF) begin errors++; $display("FAIL wrap_instr got=%h exp=0FFF", id_instr); end
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid got=%b exp=1", id_valid); end
    // Run from 0 into the HLT at 7, then reset between clock edges.
    for (int i = 0; i < 9; i++) tick();
    checks++; if (fetch_halted !== 1'b1) begin errors++; $display("FAIL prereset_halted got=%b exp=1", fetch_halted); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL async_addr got=%h exp=0000", imem_addr); end
    checks++; if (id_instr !== 16'h0000) begin errors++; $display("FAIL async_instr got=%h exp=0000", id_instr); end
    checks++; if (id_pc !== 16'h0000) begin errors++; $display("FAIL async_pc got=%h exp=0000", id_pc); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL async_valid got=%b exp=0", id_valid); end
    checks++; if (fetch_halted !== 1'b0) begin errors++; $display("FAIL async_halted got=%b exp=0", fetch_halted); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef IF_PERF_CNT_EN
  task automatic test_perf_cnt();
    rst_n = 1'b0; hlt_en = 1'b0; stall = 1'b0; redirect = 1'b0;
    #12;
    checks++; if (fetch_cnt !== 32'd0) begin errors++; $display("FAIL perf_reset_fetch got=%0d exp=0", fetch_cnt); end
    checks++; if (bubble_cnt !== 32'd0) begin errors++; $display("FAIL perf_reset_bubble got=%0d exp=0", bubble_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    stall = 1'b0; redirect = 1'b1; redirect_pc = 16'h0020;
    tick();
    tick();
    redirect = 1'b0; stall = 1'b1;
    checks++; if (fetch_cnt !== 32'd10) begin errors++; $display("FAIL perf_fetch got=%0d exp=10", fetch_cnt); end
    checks++; if (bubble_cnt !== 32'd2) begin errors++; $display("FAIL perf_bubble got=%0d exp=2", bubble_cnt); end
    stall = 1'b0;
    hlt_en = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_halt();
    test_redirect_stall();
    test_wrap_and_reset();
`ifdef IF_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage of the 5-stage pipelined core. Sits directly upstream of instruction decode.
- Owns the PC register, drives the instruction-memory address, and registers the returned instruction and PC+1 into the IF/ID pipeline register that decode consumes.
- Handles stall from hazard detection, redirect from branch/jal/jr resolution in EX, and halt detection so no instructions are fetched past HLT.

Parameters:
- PC_W, 16, PC and instruction-address width (word addressed).
- INSTR_W, 16, instruction width.
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hazard unit: hold PC and IF/ID contents.
- redirect  in  1  EX: branch taken / jal / jr resolved; load redirect_pc.
- redirect_pc  in  PC_W  target PC for redirect.
- imem_addr  out  PC_W  instruction-memory address; equals current PC.
- imem_instr  in  INSTR_W  instruction at imem_addr, combinational same cycle.
- id_instr  out  INSTR_W  IF/ID instruction to decode.
- id_pc  out  PC_W  IF/ID PC+1 of id_instr (jal link / branch base).
- id_valid  out  1  IF/ID holds a real instruction; 0 = bubble.
- fetch_halted  out  1  fetch FSM is in HALTED.

Behaviour:
- Reset (async, rst_n=0): PC=RESET_PC; id_instr=16'h0000; id_pc=0; id_valid=0; FSM=RUN; fetch_halted=0. Reset mid-operation discards all state immediately.
- imem_addr = PC combinationally. Fetch latency is 1 cycle: an instruction at PC appears on id_instr the cycle after it is addressed.
- FSM states:
  - RUN: fetch normally.
  - HALTED: PC frozen; IF/ID receives bubbles.
- Per-cycle priority is redirect > stall > halt > normal.
- redirect=1, any state:
  - PC <= redirect_pc.
  - IF/ID <= bubble (id_instr=16'h0000, id_valid=0, id_pc unchanged).
  - FSM <= RUN, which cancels a speculatively fetched HLT.
  - Redirect overrides a simultaneous stall.
- stall=1, no redirect: PC, id_instr, id_pc, id_valid and FSM all hold.
- RUN, no stall/redirect, imem_instr[15:12]==4'hF (HLT):
  - IF/ID <= {imem_instr, PC+1, valid=1}.
  - PC holds.
  - FSM <= HALTED.
- RUN, normal cycle: IF/ID <= {imem_instr, PC+1, valid=1}; PC <= PC+1.
- HALTED, no redirect: PC holds; IF/ID <= bubble; fetch_halted=1. Exit only via redirect or reset.
- Arithmetic and encoding:
  - PC+1 wraps modulo 2^PC_W (16'hFFFF -> 16'h0000). No error is raised on wrap.
  - Bubble encoding is all-zero with id_valid=0. Downstream must qualify we_rf/we_mem with id_valid.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined:
  - Adds output ports fetch_cnt (32 bits) and bubble_cnt (32 bits), both reset to 0.
  - fetch_cnt increments on each cycle that IF/ID loads valid=1.
  - bubble_cnt increments on each cycle that IF/ID loads a bubble. Stall cycles count toward neither.
  - Both counters saturate at all-ones.
- Undefined: the ports and counters do not exist, with zero area cost.

Decomposition:
- Shared package cpu_pkg:
  - opcode localparams (OP_HLT=4'hF and the remaining ISA opcodes).
  - INSTR_W/PC_W constants.
  - BUBBLE_INSTR=16'h0000.
  - Fetch FSM state encoding (FS_RUN, FS_HALTED).
- One natural sub-module: if_id_reg, the IF/ID pipeline register with hold (stall) and flush (bubble) controls and async active-low reset. It is reused for the remaining pipeline registers.
- The PC/FSM logic stays in instr_fetch.

Test Plan:
- Sequential fetch: reset then release, imem returns 16'h1000+addr, no stall/redirect → imem_addr 0,1,2,3 on consecutive cycles; id_instr lags one cycle; id_pc = addr+1; id_valid=1 from the first post-reset edge.
- Stall: assert stall for 3 cycles at PC=5 → imem_addr stays 5 and IF/ID holds the instruction from addr 4 for 3 cycles; PC=6 on release.
- Redirect with stall: stall=1, redirect=1, redirect_pc=16'h0040 in the same cycle → next cycle imem_addr=16'h0040, id_valid=0; the following cycle id_instr = instr@0x40.
- Halt: HLT (16'hF000) at addr 7 → id_instr=16'hF000 with valid=1; then PC frozen at 7, id_valid=0, fetch_halted=1 indefinitely. A redirect to 16'h0002 resumes fetch at 2 with fetch_halted=0.
- Wrap and reset: start at PC=16'hFFFF → next imem_addr=16'h0000, id_pc=16'h0000. Assert rst_n low mid-cycle → outputs reset immediately without waiting for clk.
- IF_PERF_CNT_EN: 10 normal fetches, 2 redirects, 3 stall cycles → fetch_cnt=10, bubble_cnt=2.
